gcd_dispatch: RTL and testbench

Upstream sequencer for the `gcd` HLS core. It buffers operand pairs arriving on a valid/ready stream in a small FIFO and drives the core's `ap_start`-style handshake one pair at a time. It captures `ap_return` on done and presents each result, in order, on a valid/ready output stream together with a per-job cycle count. Pairs containing a zero operand are resolved locally without starting the core.

---
 rtl/gcd_dispatch.sv | 146 ++++++++++++++
 tb/tb_gcd_dispatch.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_dispatch.sv
// Operand FIFO and ap_start-style sequencer in front of the gcd HLS core.
// Results leave in order on a valid/ready stream with a per-job busy cycle count.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a queued pair; bypasses zero pairs, launches others
// RUN   | core running, gcd_start held high, busy cycles counted
// HOLD  | result presented on out_valid until out_ready
module gcd_dispatch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  output logic             gcd_start,
  input  logic             gcd_done,
  input  logic             gcd_idle,
  input  logic [WIDTH-1:0] gcd_return,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [15:0]      out_cycles
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [15:0]      run_cnt;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             head_zero;
  logic             bypass;
  logic             launch;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign in_ready  = !full && !ap_rst;
  assign push      = in_valid && in_ready;
  assign head_a    = mem_a[rd_ptr];
  assign head_b    = mem_b[rd_ptr];
  assign head_zero = (head_a == '0) || (head_b == '0);
  assign bypass    = (state == S_IDLE) && !empty && head_zero;
  assign launch    = (state == S_IDLE) && !empty && !head_zero && gcd_idle;
  // The head stays queued while the core runs; it leaves only on completion.
  assign pop       = bypass || ((state == S_RUN) && gcd_done);

  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= S_IDLE;
      gcd_a      <= '0;
      gcd_b      <= '0;
      gcd_start  <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_cycles <= '0;
      run_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bypass) begin
            out_result <= (head_a == '0) ? head_b : head_a;
            out_cycles <= '0;
            out_valid  <= 1'b1;
            state      <= S_HOLD;
          end else if (launch) begin
            gcd_a     <= head_a;
            gcd_b     <= head_b;
            run_cnt   <= '0;
            gcd_start <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          // The done edge itself is one of the counted start-high edges.
          if (gcd_done) begin
            out_result <= gcd_return;
            out_cycles <= sat_inc(run_cnt);
            gcd_start  <= 1'b0;
            out_valid  <= 1'b1;
            state      <= S_HOLD;
          end else begin
            run_cnt <= sat_inc(run_cnt);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_dispatch.sv
// Bench for gcd_dispatch: behavioural gcd core, queue-based result model,
// and directed scenarios with literal expectations.
module tb_gcd_dispatch;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             ap_clk = 1'b0;
  logic             ap_rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic             gcd_start;
  logic             gcd_done;
  logic             gcd_idle;
  logic [WIDTH-1:0] gcd_return;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [15:0]      out_cycles;

  gcd_dispatch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .gcd_a     (gcd_a),
    .gcd_b     (gcd_b),
    .gcd_start (gcd_start),
    .gcd_done  (gcd_done),
    .gcd_idle  (gcd_idle),
    .gcd_return(gcd_return),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_cycles(out_cycles)
  );

  initial forever #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural core: latches operands on start, answers after core_lat cycles.
  int          core_lat = 5;
  bit          core_busy = 0;
  bit          force_idle_low = 0;
  int          rem;
  logic [31:0] ca, cb;

  assign gcd_idle = !core_busy && !force_idle_low;

  initial begin
    gcd_done   = 1'b0;
    gcd_return = '0;
    forever begin
      @(posedge ap_clk);
      #1;
      if (gcd_done) begin
        gcd_done  = 1'b0;
        core_busy = 0;
      end else if (core_busy) begin
        rem--;
        if (rem == 0) begin
          gcd_done   = 1'b1;
          gcd_return = ref_gcd(ca, cb);
        end
      end else if (gcd_start) begin
        ca        = gcd_a;
        cb        = gcd_b;
        rem       = core_lat;
        core_busy = 1;
      end
    end
  end

  // Result model: one expected entry per accepted pair, in arrival order.
  typedef struct {
    logic [31:0] res;
    bit          zero;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] got_res[$];
  logic [15:0] got_cyc[$];
  int          n_out = 0;
  int          start_rises = 0;
  int          stall_seen = 0;
  int          run_cnt = 0;
  int          last_run = 0;
  bit          prev_start = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_ga, prev_gb, prev_res;
  logic [15:0] prev_cyc;

  // Values seen at the falling edge are those sampled by the next rising edge.
  initial forever begin
    @(negedge ap_clk);
    if (ap_rst) begin
      exp_q.delete();
      run_cnt    = 0;
      prev_hold  = 0;
      prev_start = 0;
    end else begin
      if (in_valid && !in_ready) stall_seen++;
      if (in_valid && in_ready) begin
        e.res  = ref_gcd(in_a, in_b);
        e.zero = (in_a == 0) || (in_b == 0);
        exp_q.push_back(e);
      end
      if (gcd_start && !prev_start) start_rises++;
      if (gcd_start && prev_start) begin
        check("gcd_a_stable", gcd_a, prev_ga);
        check("gcd_b_stable", gcd_b, prev_gb);
      end
      if (gcd_start) begin
        run_cnt++;
        if (gcd_done) begin
          check("start_high_edges", 32'(run_cnt), 32'(core_lat + 1));
          last_run = run_cnt;
          run_cnt  = 0;
        end
      end
      if (out_valid) check("no_launch_in_hold", 32'(gcd_start), 32'd0);
      if (prev_hold && out_valid) begin
        check("hold_result_stable", out_result, prev_res);
        check("hold_cycles_stable", 32'(out_cycles), 32'(prev_cyc));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got result %0d expected no output", out_result);
        end else begin
          e = exp_q.pop_front();
          check("result", out_result, e.res);
          check("cycles", 32'(out_cycles), e.zero ? 32'd0 : 32'(last_run));
        end
        got_res.push_back(out_result);
        got_cyc.push_back(out_cycles);
        n_out++;
      end
      prev_hold  = out_valid && !out_ready;
      prev_res   = out_result;
      prev_cyc   = out_cycles;
      prev_start = gcd_start;
      prev_ga    = gcd_a;
      prev_gb    = gcd_b;
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok       = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge ap_clk);
      if (in_ready) ok = 1;
    end
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic wait_outs(input int target, input int budget);
    int k;
    k = 0;
    while (n_out < target && k < budget) begin
      tick();
      k++;
    end
    if (n_out < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_outputs: got %0d outputs expected %0d", n_out, target);
    end
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!out_valid && k < budget) begin
      tick();
      k++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_out_valid: got 0 expected 1 within %0d cycles", budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

  int          out0, rises0, stall0;
  bit          bad;
  logic [31:0] exp5 [5];

  initial begin
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset values
    tick();
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("rst_gcd_start", 32'(gcd_start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_cycles", 32'(out_cycles), 32'd0);
    check("rst_gcd_a", gcd_a, 32'd0);
    check("rst_gcd_b", gcd_b, 32'd0);
    ap_rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    tick();

    // Single nonzero pair (24,56), core latency 5
    core_lat = 5;
    rises0   = start_rises;
    out0     = n_out;
    push(32'd24, 32'd56);
    check("start_low_after_push", 32'(gcd_start), 32'd0);
    tick();
    check("start_high_2_after_push", 32'(gcd_start), 32'd1);
    wait_valid(40);
    check("gcd_24_56", out_result, 32'd8);
    check("cycles_24_56", 32'(out_cycles), 32'd6);
    wait_outs(out0 + 1, 10);
    repeat (5) tick();
    check("single_start_rise", 32'(start_rises - rises0), 32'd1);

    // Zero-operand bypass
    rises0 = start_rises;
    out0   = n_out;
    push(32'd0, 32'd35);
    push(32'd0, 32'd0);
    wait_outs(out0 + 2, 30);
    check("bypass_0_35", got_res[out0], 32'd35);
    check("bypass_0_0", got_res[out0 + 1], 32'd0);
    check("bypass_cyc_a", 32'(got_cyc[out0]), 32'd0);
    check("bypass_cyc_b", 32'(got_cyc[out0 + 1]), 32'd0);
    check("bypass_no_start", 32'(start_rises - rises0), 32'd0);

    // Five back-to-back pairs, FIFO fills
    core_lat = 4;
    out0     = n_out;
    stall0   = stall_seen;
    exp5     = '{32'd6, 32'd1, 32'd25, 32'd9, 32'd12};
    push(32'd12, 32'd18);
    push(32'd7, 32'd13);
    push(32'd100, 32'd75);
    push(32'd9, 32'd27);
    check("in_ready_full", 32'(in_ready), 32'd0);
    push(32'd48, 32'd36);
    check("stalled_when_full", 32'(stall_seen > stall0), 32'd1);
    wait_outs(out0 + 5, 200);
    for (int i = 0; i < 5; i++) check("burst_result", got_res[out0 + i], exp5[i]);
    check("burst_all_drained", 32'(exp_q.size()), 32'd0);

    // Consumer back-pressure in HOLD
    core_lat  = 3;
    out_ready = 1'b0;
    out0      = n_out;
    push(32'd21, 32'd14);
    push(32'd10, 32'd4);
    wait_valid(30);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result_7", out_result, 32'd7);
      check("hold_no_start", 32'(gcd_start), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("accept_valid_low", 32'(out_valid), 32'd0);
    check("accept_start_low", 32'(gcd_start), 32'd0);
    tick();
    check("launch_2_after_accept", 32'(gcd_start), 32'd1);
    wait_outs(out0 + 2, 30);
    check("after_hold_result", got_res[out0 + 1], 32'd2);

    // Reset pulse during RUN with three pairs queued behind the running one
    core_lat = 20;
    out0     = n_out;
    push(32'd15, 32'd25);
    push(32'd8, 32'd12);
    push(32'd30, 32'd45);
    push(32'd14, 32'd21);
    check("running_before_rst", 32'(gcd_start), 32'd1);
    ap_rst = 1'b1;
    tick();
    check("rst_mid_start", 32'(gcd_start), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    ap_rst = 1'b0;
    #1;
    check("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid || gcd_start) bad = 1;
    end
    check("flushed_no_activity", 32'(bad), 32'd0);
    check("flushed_no_output", 32'(n_out - out0), 32'd0);
    for (int i = 0; i < 50 && core_busy; i++) tick();
    check("core_drained", 32'(core_busy), 32'd0);

    // Core not idle: no launch until gcd_idle rises
    core_lat       = 2;
    force_idle_low = 1;
    out0           = n_out;
    push(32'd18, 32'd24);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gcd_start) bad = 1;
    end
    check("no_start_while_busy", 32'(bad), 32'd0);
    force_idle_low = 0;
    tick();
    check("launch_after_idle", 32'(gcd_start), 32'd1);
    wait_outs(out0 + 1, 20);
    check("idle_gate_result", got_res[out0], 32'd6);

    repeat (3) tick();
    check("model_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
